mul_seq: RTL and testbench

- Multi-cycle 32x32->64 shift-add multiplier sequencer.
- Performs every partial-product addition on the shared 32-bit ALU (add function), reached through an alu_req/alu_gnt handshake.
- Sits beside the execute stage and services MULT/MULTU, producing HI/LO.
- Holds no adder of its own wider than the sign-fix negation.

---
 rtl/mul_seq.sv | 152 +++++++++++++++
 tb/tb_mul_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequential 32x32->64 shift-add multiplier for MULT/MULTU.
// All partial-product additions are borrowed from the shared ALU via alu_req/alu_gnt.
module mul_seq #(
  parameter logic [2:0] ALU_ADD_FUNC = 3'd0,
  parameter int         ITERS        = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_func,
  input  logic [31:0] alu_res
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_mcand;
  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  logic        r_neg;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_add;
  logic        w_step;
  logic        w_last;
  logic        w_carry;
  logic [63:0] w_prod;
  logic [63:0] w_prod_neg;

  // Operands are reduced to magnitudes; the sign is reapplied once in FIX.
  assign w_a_mag    = (is_signed && a[31]) ? (~a + 32'd1) : a;
  assign w_b_mag    = (is_signed && b[31]) ? (~b + 32'd1) : b;

  assign w_add      = (r_state == S_ITER) && r_acc_lo[0];
  assign w_step     = (r_state == S_ITER) && (!r_acc_lo[0] || alu_gnt);
  assign w_last     = (r_cnt == 5'(ITERS - 1));
  // A 32-bit unsigned sum wrapped iff it came out smaller than an addend.
  assign w_carry    = (alu_res < r_acc_hi);
  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_neg = ~w_prod + 64'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != S_IDLE);
    done         = 1'b0;
    alu_req      = 1'b0;
    alu_a        = 32'd0;
    alu_b        = 32'd0;
    alu_func     = ALU_ADD_FUNC;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_ITER;
        end
      end
      S_ITER: begin
        if (w_add) begin
          alu_req = 1'b1;
          alu_a   = r_acc_hi;
          alu_b   = r_mcand;
        end
        if (w_step && w_last) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= 32'd0;
      r_acc_hi <= 32'd0;
      r_acc_lo <= 32'd0;
      r_neg    <= 1'b0;
      r_cnt    <= 5'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= w_a_mag;
            r_acc_lo <= w_b_mag;
            r_acc_hi <= 32'd0;
            r_neg    <= is_signed & (a[31] ^ b[31]);
            r_cnt    <= 5'd0;
          end
        end
        S_ITER: begin
          // A denied request leaves every register untouched (full stall).
          if (w_step) begin
            if (r_acc_lo[0]) begin
              {r_acc_hi, r_acc_lo} <= {w_carry, alu_res, r_acc_lo[31:1]};
            end else begin
              {r_acc_hi, r_acc_lo} <= {1'b0, r_acc_hi, r_acc_lo[31:1]};
            end
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_FIX: begin
          {r_hi, r_lo} <= r_neg ? w_prod_neg : w_prod;
        end
        default: begin
        end
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mul_seq.sv
// Randomized self-checking bench for mul_seq against a plain-arithmetic product model.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        is_signed = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        alu_req;
  logic        alu_gnt = 1'b0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_func;
  logic [31:0] alu_res;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_prev = 64'd0;

  mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .alu_req   (alu_req),
    .alu_gnt   (alu_gnt),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_func  (alu_func),
    .alu_res   (alu_res)
  );

  // Shared combinational ALU stand-in: only the add function is meaningful.
  assign alu_res = (alu_func == 3'd0) ? (alu_a + alu_b) : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sx, sy;
    if (s) begin
      sx = $signed({{32{x[31]}}, x});
      sy = $signed({{32{y[31]}}, y});
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? (32'd0 - x) : x;
  endfunction

  task automatic do_mul(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input int deny_first, input bit gnt_rand, input bit extra_pulse);
    logic [63:0] exp_p;
    logic [31:0] pa, pb;
    int          cyc, grants, denies, left;
    bit          seen, pden, bad_busy, bad_idle, bad_opnd, bad_stall, bad_hold;
    exp_p  = ref_prod(ta, tb, ts);
    cyc    = 0; grants = 0; denies = 0; left = deny_first;
    seen   = 0; pden = 0; bad_busy = 0; bad_idle = 0; bad_opnd = 0; bad_stall = 0; bad_hold = 0;
    pa     = 32'd0; pb = 32'd0;
    chk("idle_busy", {63'd0, busy}, 64'd0);
    a = ta; b = tb; is_signed = ts; start = 1'b1;
    while (!seen && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start = extra_pulse && (cyc == 5);
      if (alu_req && left > 0) begin
        alu_gnt = 1'b0;
        left--;
      end else begin
        alu_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      if (busy !== 1'b1) bad_busy = 1;
      if (done === 1'b1) seen = 1;
      else if ({hi, lo} !== exp_prev) bad_hold = 1;
      if (alu_req === 1'b1) begin
        if (alu_b !== mag(ta, ts) || alu_func !== 3'd0) bad_opnd = 1;
        if (pden && (alu_a !== pa || alu_b !== pb)) bad_stall = 1;
        if (alu_gnt) grants++;
        else denies++;
        pden = !alu_gnt;
        pa = alu_a;
        pb = alu_b;
      end else begin
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_func !== 3'd0) bad_idle = 1;
        if (pden) bad_stall = 1;
        pden = 0;
      end
    end
    chk("latency", 64'(cyc), 64'(34 + denies));
    chk("alu_grants", 64'(grants), 64'($countones(mag(tb, ts))));
    chk("product", {hi, lo}, exp_p);
    chk("busy_during_op", {63'd0, bad_busy}, 64'd0);
    chk("alu_idle_outputs", {63'd0, bad_idle}, 64'd0);
    chk("alu_operands", {63'd0, bad_opnd}, 64'd0);
    chk("stall_stable", {63'd0, bad_stall}, 64'd0);
    chk("hilo_hold", {63'd0, bad_hold}, 64'd0);
    if (deny_first > 0) chk("denied_cycles", 64'(denies), 64'(deny_first));
    // start raised while in DONE must not launch a new operation
    a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    alu_gnt = 1'b0;
    #1;
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("start_in_done_ignored", {63'd0, busy}, 64'd0);
    $display("mul a=%h b=%h signed=%0d -> hi=%h lo=%h cycles=%0d denied=%0d",
             ta, tb, ts, hi, lo, cyc, denies);
    exp_prev = exp_p;
  endtask

  initial begin
    bit bad_rst;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_req", {63'd0, alu_req}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_mul(32'd7, 32'd6, 1'b0, 0, 0, 0);
    do_mul(32'hFFFF_FFFD, 32'd5, 1'b1, 0, 0, 0);
    do_mul(32'hFFFF_FFFD, 32'd5, 1'b0, 0, 0, 0);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
    do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, 0);
    do_mul(32'd7, 32'd6, 1'b0, 5, 0, 0);
    do_mul(32'h0001_2345, 32'h0000_6789, 1'b1, 0, 0, 1);
    do_mul(32'd0, 32'hFFFF_FFFF, 1'b1, 0, 1, 0);
    do_mul(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      do_mul($urandom, $urandom, 1'($urandom_range(0, 1)), 0, 1, 0);
    end

    // Reset in the middle of an operation
    do_mul(32'd7, 32'd6, 1'b0, 0, 0, 0);
    a = 32'h0001_0000; b = 32'h0001_0000; is_signed = 1'b0; start = 1'b1; alu_gnt = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      start = (k == 5);
    end
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    chk("pre_rst_hilo", {hi, lo}, 64'd42);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    chk("async_rst_done", {63'd0, done}, 64'd0);
    chk("async_rst_req", {63'd0, alu_req}, 64'd0);
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    bad_rst = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad_rst = 1;
    end
    chk("rst_held_quiet", {63'd0, bad_rst}, 64'd0);
    rst = 1'b0;
    alu_gnt = 1'b0;
    exp_prev = 64'd0;
    @(posedge clk); #1;
    do_mul(32'd3, 32'd3, 1'b0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
